instruction_memory_writer: RTL and testbench
============================================

INSTRUCTION_MEMORY_WRITER -- requirements
Module: Instruction_Memory_Writer

Interface
REQ-001 Parameter DEPTH, 16, byte capacity of the target instruction memory; power of two, at least 4.
REQ-002 Parameter ADDR_W, 4, log2(DEPTH); width of the internal write pointer.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-low.
REQ-005 Load_Start  input  1  single-cycle request to set the base address.
REQ-006 Start_Address  input  64  base byte address, sampled with Load_Start.
REQ-007 Word_Valid  input  1  producer has an instruction word on Word_Data.
REQ-008 Word_Data  input  32  instruction word to store.
REQ-009 Word_Ready  output  1  block accepts Word_Data this cycle.
REQ-010 Mem_Write_Enable  output  1  byte write strobe to the instruction memory.
REQ-011 Mem_Write_Address  output  64  byte address of the write, zero-extended write pointer.
REQ-012 Mem_Write_Data  output  8  byte to write.
REQ-013 Busy  output  1  a word is being written.
REQ-014 Words_Written  output  8  count of completed words, saturating at 255.
REQ-015 Overflow  output  1  sticky flag: the pointer wrapped from DEPTH-1 to 0.

Function
REQ-016 The FSM SHALL have states IDLE and WRITE, with a 2-bit byte index (0..3) in WRITE.
REQ-017 A word SHALL be accepted on a rising edge where Word_Valid and Word_Ready are both 1; Word_Data is captured in a holding register.
REQ-018 Word_Ready SHALL be 1 in IDLE (unless Load_Start=1) and in WRITE with byte index 3; it is 0 otherwise.
REQ-019 After acceptance, WRITE SHALL issue 4 consecutive cycles with Mem_Write_Enable=1 and byte index 0,1,2,3.
REQ-020 Bytes SHALL be written little-endian: index k drives Word_Data[8k+7:8k] to pointer+k mod DEPTH.
REQ-021 Latency: accept at edge N; bytes are presented in cycles N..N+3 after that edge; the pointer advances by 1 per byte.
REQ-022 At byte index 3, the block SHALL increment Words_Written (saturating) and then re-enter WRITE index 0 if a new word is accepted in that cycle, else enter IDLE; back-to-back throughput is one word per 4 cycles.
REQ-023 In non-write cycles, Mem_Write_Enable, Mem_Write_Data and Mem_Write_Address SHALL be 0.
REQ-024 Busy SHALL equal 1 exactly while in WRITE.
REQ-025 Load_Start in IDLE SHALL set pointer = {Start_Address[ADDR_W-1:2], 2'b00}, which word-aligns it and discards the upper bits.
REQ-026 Load_Start in IDLE SHALL also clear Words_Written and Overflow.
REQ-027 Load_Start in IDLE SHALL win over a simultaneous Word_Valid; no word is accepted that cycle.
REQ-028 Load_Start in WRITE SHALL be ignored entirely.
REQ-029 The pointer SHALL wrap modulo DEPTH; Overflow is set on the edge where the pointer goes from DEPTH-1 to 0, and stays set until reset or Load_Start.
REQ-030 Word_Valid without Word_Ready SHALL cause no state change; the producer holds Word_Data.

Reset
REQ-031 While reset=0 at a rising edge: state=IDLE, index=0, pointer=0, Words_Written=0, Overflow=0, holding register=0.
REQ-032 Word_Ready SHALL be 0 during any cycle in which reset=0.
REQ-033 Reset mid-word SHALL abandon the word; bytes already written stay in memory, and the count is not incremented.

Verification
REQ-034 Reset, Load_Start with address 0, then Word_Data=0x02853483 -> writes 0x83@0, 0x34@1, 0x85@2, 0x02@3 on 4 consecutive cycles; Words_Written=1; Busy high for exactly 4 cycles.
REQ-035 Four back-to-back words (0x02853483, 0x009A84B3, 0x00148493, 0x02953423), Word_Valid held high -> 16 consecutive write cycles at addresses 0..15; Words_Written=4; Overflow=1 after the last byte; pointer=0.
REQ-036 Load_Start with Start_Address=0x9 -> the next word is written at addresses 8..11; Load_Start with Word_Valid=1 in the same cycle -> Word_Ready=0 and no write that cycle.
REQ-037 Reset asserted after 2 bytes of a word -> the remaining 2 bytes are never written; Words_Written=0; Word_Ready=1 in the first IDLE cycle after release.
REQ-038 Load_Start pulsed during WRITE -> ignored; the word completes at its original addresses; the counters are unchanged except for the normal increment.
REQ-039 Word_Valid low for 10 cycles -> Mem_Write_Enable stays 0; outputs stay 0; Words_Written is unchanged.

Source files
------------

// File: rtl/instruction_memory_writer.sv
// -----------------------------------------------------------------------------
// instruction_memory_writer
//
// Purpose:
//   Accepts 32-bit instruction words over a valid/ready handshake and writes
//   each word into a byte-wide instruction memory. Each word becomes four
//   little-endian byte writes on consecutive cycles at an auto-incrementing
//   pointer. The pointer wraps modulo DEPTH. A sticky flag records the wrap.
//
// Ports:
//   clk               - sole clock, rising-edge
//   reset             - synchronous, active-low
//   Load_Start        - single-cycle request to load the base address (IDLE only)
//   Start_Address     - base byte address; word-aligned and truncated to ADDR_W
//   Word_Valid        - producer presents a word on Word_Data
//   Word_Data         - instruction word
//   Word_Ready        - word is accepted on this cycle's edge if Word_Valid=1
//   Mem_Write_Enable  - byte write strobe
//   Mem_Write_Address - zero-extended write pointer (0 when not writing)
//   Mem_Write_Data    - byte to write (0 when not writing)
//   Busy              - high while a word is being written
//   Words_Written     - completed words, saturating at 255
//   Overflow          - sticky: pointer wrapped from DEPTH-1 to 0
// -----------------------------------------------------------------------------
module instruction_memory_writer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Load_Start,
    input  logic [63:0] Start_Address,
    input  logic        Word_Valid,
    input  logic [31:0] Word_Data,
    output logic        Word_Ready,
    output logic        Mem_Write_Enable,
    output logic [63:0] Mem_Write_Address,
    output logic [7:0]  Mem_Write_Data,
    output logic        Busy,
    output logic [7:0]  Words_Written,
    output logic        Overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]         hold_q, hold_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                accept;

    // Only Start_Address[ADDR_W-1:2] sets the pointer; the rest is discarded.
    logic unused_start_bits;
    assign unused_start_bits = ^{Start_Address[63:ADDR_W], Start_Address[1:0]};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept = Word_Valid && Word_Ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= '0;
            hold_q  <= 32'd0;
            cnt_q   <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                // Load_Start outranks a simultaneous word (Word_Ready is 0).
                if (Load_Start) begin
                    ptr_d = {Start_Address[ADDR_W-1:2], 2'b00};
                    cnt_d = 8'd0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    hold_d  = Word_Data;
                    idx_d   = 2'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Pointer advances once per byte and wraps naturally at ADDR_W bits.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    ovf_d = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    cnt_d = sat_inc8(cnt_q);
                    idx_d = 2'd0;
                    if (accept) begin
                        hold_d = Word_Data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Word_Ready        = 1'b0;
        Busy              = (state_q == WRITE);
        Mem_Write_Enable  = 1'b0;
        Mem_Write_Address = 64'd0;
        Mem_Write_Data    = 8'd0;
        Words_Written     = cnt_q;
        Overflow          = ovf_q;
        if (reset) begin
            if (state_q == IDLE) begin
                Word_Ready = !Load_Start;
            end else begin
                // Last byte cycle doubles as the accept slot for the next word.
                Word_Ready = (idx_q == 2'd3);
            end
        end
        if (state_q == WRITE) begin
            Mem_Write_Enable  = 1'b1;
            Mem_Write_Address = {{(64 - ADDR_W){1'b0}}, ptr_q};
            Mem_Write_Data    = hold_q[8*idx_q +: 8];
        end
    end

endmodule

// File: tb/tb_instruction_memory_writer.sv
module tb_instruction_memory_writer;

    logic        clk;
    logic        reset;
    logic        Load_Start;
    logic [63:0] Start_Address;
    logic        Word_Valid;
    logic [31:0] Word_Data;
    logic        Word_Ready;
    logic        Mem_Write_Enable;
    logic [63:0] Mem_Write_Address;
    logic [7:0]  Mem_Write_Data;
    logic        Busy;
    logic [7:0]  Words_Written;
    logic        Overflow;

    instruction_memory_writer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .Load_Start        (Load_Start),
        .Start_Address     (Start_Address),
        .Word_Valid        (Word_Valid),
        .Word_Data         (Word_Data),
        .Word_Ready        (Word_Ready),
        .Mem_Write_Enable  (Mem_Write_Enable),
        .Mem_Write_Address (Mem_Write_Address),
        .Mem_Write_Data    (Mem_Write_Data),
        .Busy              (Busy),
        .Words_Written     (Words_Written),
        .Overflow          (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  busy_cycles = 0;
    int  run_len = 0;
    int  max_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [63:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Little-endian split of a word into expected byte writes from base.
    task automatic expect_word(input logic [31:0] w, input int base, input int nb);
        for (int k = 0; k < nb; k++) begin
            expect_wr(64'((base + k) % 16), w[8*k +: 8]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; returns #1 after the accept edge.
    task automatic put_word(input logic [31:0] w);
        int t;
        Word_Valid = 1'b1;
        Word_Data  = w;
        t = 0;
        forever begin
            @(negedge clk);
            if (Word_Ready) break;
            t++;
            if (t > 20) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        Word_Valid = 1'b0;
    endtask

    task automatic load(input logic [63:0] a);
        Load_Start    = 1'b1;
        Start_Address = a;
        tick(1);
        Load_Start    = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every write strobe, checks quiet outputs otherwise.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (Busy) busy_cycles++;
            if (Mem_Write_Enable) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            chk("busy_vs_we", 64'(Busy), 64'(Mem_Write_Enable));
            if (Mem_Write_Enable) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected (t=%0t)",
                             Mem_Write_Address, Mem_Write_Data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", Mem_Write_Address, e.a);
                    chk("wr_data", 64'(Mem_Write_Data), 64'(e.d));
                end
            end else begin
                chk("idle_addr", Mem_Write_Address, 64'd0);
                chk("idle_data", 64'(Mem_Write_Data), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        Load_Start    = 1'b0;
        Start_Address = 64'd0;
        Word_Valid    = 1'b0;
        Word_Data     = 32'd0;

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_ready", 64'(Word_Ready), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_ww", 64'(Words_Written), 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        tick(1);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(Word_Ready), 64'd1);

        // Single word at address 0
        tick(1);
        load(64'd0);
        expect_wr(64'd0, 8'h83);
        expect_wr(64'd1, 8'h34);
        expect_wr(64'd2, 8'h85);
        expect_wr(64'd3, 8'h02);
        busy_cycles = 0;
        put_word(32'h02853483);
        tick(8);
        chk("t1_ww", 64'(Words_Written), 64'd1);
        chk("t1_busy_cycles", 64'(busy_cycles), 64'd4);

        // Four back-to-back words filling 0..15 and wrapping
        load(64'd0);
        chk("t2_ww_cleared", 64'(Words_Written), 64'd0);
        max_run = 0;
        expect_word(32'h02853483, 0, 4);
        expect_word(32'h009A84B3, 4, 4);
        expect_word(32'h00148493, 8, 4);
        expect_word(32'h02953423, 12, 4);
        put_word(32'h02853483);
        put_word(32'h009A84B3);
        put_word(32'h00148493);
        put_word(32'h02953423);
        tick(8);
        chk("t2_ww", 64'(Words_Written), 64'd4);
        chk("t2_ovf", 64'(Overflow), 64'd1);
        chk("t2_run", 64'(max_run), 64'd16);
        // Pointer wrapped to 0
        expect_wr(64'd0, 8'h0D);
        expect_wr(64'd1, 8'hF0);
        expect_wr(64'd2, 8'hFE);
        expect_wr(64'd3, 8'hCA);
        put_word(32'hCAFEF00D);
        tick(8);
        chk("t2_ww5", 64'(Words_Written), 64'd5);

        // Load_Start with unaligned address and simultaneous Word_Valid
        Load_Start    = 1'b1;
        Start_Address = 64'hFFFF_0000_0000_0009;
        Word_Valid    = 1'b1;
        Word_Data     = 32'hDEADBEEF;
        @(negedge clk);
        chk("t3_ready_lost", 64'(Word_Ready), 64'd0);
        tick(1);
        Load_Start = 1'b0;
        Word_Valid = 1'b0;
        @(negedge clk);
        chk("t3_no_accept", 64'(Busy), 64'd0);
        chk("t3_ww_cleared", 64'(Words_Written), 64'd0);
        chk("t3_ovf_cleared", 64'(Overflow), 64'd0);
        tick(1);
        expect_wr(64'd8, 8'h44);
        expect_wr(64'd9, 8'h33);
        expect_wr(64'd10, 8'h22);
        expect_wr(64'd11, 8'h11);
        put_word(32'h11223344);
        // Load_Start during WRITE must be ignored
        Load_Start    = 1'b1;
        Start_Address = 64'd4;
        tick(1);
        Load_Start = 1'b0;
        tick(6);
        chk("t4_ww", 64'(Words_Written), 64'd1);
        chk("t4_ovf", 64'(Overflow), 64'd0);
        expect_word(32'h55667788, 12, 4);
        put_word(32'h55667788);
        tick(6);
        chk("t4_ww2", 64'(Words_Written), 64'd2);
        chk("t4_ovf_wrap", 64'(Overflow), 64'd1);

        // Reset after two bytes of a word (pointer is 0 here)
        expect_wr(64'd0, 8'hDD);
        expect_wr(64'd1, 8'hCC);
        put_word(32'hAABBCCDD);
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready_in_rst", 64'(Word_Ready), 64'd0);
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_ready", 64'(Word_Ready), 64'd1);
        chk("t5_ww", 64'(Words_Written), 64'd0);
        chk("t5_ovf", 64'(Overflow), 64'd0);
        chk("t5_busy", 64'(Busy), 64'd0);

        // Quiet period: no writes, count unchanged
        tick(1);
        expect_word(32'h0A0B0C0D, 0, 4);
        put_word(32'h0A0B0C0D);
        tick(6);
        chk("t6_ww_before", 64'(Words_Written), 64'd1);
        tick(10);
        chk("t6_ww_after", 64'(Words_Written), 64'd1);
        chk("t6_we", 64'(Mem_Write_Enable), 64'd0);

        // Saturation at 255
        load(64'd0);
        for (int i = 0; i < 260; i++) begin
            logic [31:0] w;
            w = 32'h01010101 * 32'(i & 8'hFF) ^ 32'h5A000000;
            expect_word(w, (4 * i) % 16, 4);
            put_word(w);
        end
        tick(8);
        chk("t7_ww_sat", 64'(Words_Written), 64'd255);
        chk("t7_ovf", 64'(Overflow), 64'd1);

        tick(2);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
